// File: rtl/mmio_io_unit.sv
// CPU IO-bus peripheral: LED register, synchronized switches, single-entry TX
// buffer, RX FIFO and sticky error flags, with a combinational read path.
module mmio_io_unit #(
    parameter int RX_DEPTH = 4,
    parameter int LED_W    = 16,
    parameter int SW_W     = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [7:0]       io_addr,
    input  logic [31:0]      io_dout,
    input  logic             io_we,
    input  logic             io_rd,
    output logic [31:0]      io_din,
    output logic [LED_W-1:0] led,
    input  logic [SW_W-1:0]  sw,
    output logic [31:0]      tx_data,
    output logic             tx_vld,
    input  logic             tx_rdy,
    input  logic [31:0]      rx_data,
    input  logic             rx_vld,
    output logic             rx_rdy
);
    localparam int PW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
    localparam int CW = PW + 1;

    localparam logic [7:0] A_LED     = 8'h00;
    localparam logic [7:0] A_TX_STAT = 8'h04;
    localparam logic [7:0] A_TX_DATA = 8'h08;
    localparam logic [7:0] A_RX_STAT = 8'h0C;
    localparam logic [7:0] A_RX_DATA = 8'h10;
    localparam logic [7:0] A_ERR     = 8'h14;
    localparam logic [7:0] A_SW      = 8'h18;

    logic [LED_W-1:0] led_q, led_d;
    logic [SW_W-1:0]  sw_meta_q, sw_sync_q;
    logic [31:0]      tx_data_q, tx_data_d;
    logic             tx_vld_q, tx_vld_d;
    logic [1:0]       err_q, err_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [31:0]      mem [RX_DEPTH];

    logic wr_led, wr_tx, wr_err, rd_rx, push, pop, ovr_set, udr_set;

    assign wr_led  = io_we && (io_addr == A_LED);
    assign wr_tx   = io_we && (io_addr == A_TX_DATA);
    assign wr_err  = io_we && (io_addr == A_ERR);
    assign rd_rx   = io_rd && (io_addr == A_RX_DATA);
    assign rx_rdy  = (cnt_q < CW'(RX_DEPTH));
    assign push    = rx_vld && rx_rdy;
    assign pop     = rd_rx && (cnt_q != '0);
    assign udr_set = rd_rx && (cnt_q == '0);
    // A store into a slot that is still held and not draining this edge is lost.
    assign ovr_set = wr_tx && tx_vld_q && !tx_rdy;

    assign led     = led_q;
    assign tx_data = tx_data_q;
    assign tx_vld  = tx_vld_q;

    always_comb begin
        io_din = '0;
        case (io_addr)
            A_LED:     io_din = 32'(led_q);
            A_TX_STAT: io_din[0] = ~tx_vld_q;
            A_RX_STAT: begin
                io_din[0]   = (cnt_q != '0);
                io_din[8:4] = 5'(cnt_q);
            end
            A_RX_DATA: if (cnt_q != '0) io_din = mem[rptr_q];
            A_ERR:     io_din[1:0] = err_q;
            A_SW:      io_din = 32'(sw_sync_q);
            default:   io_din = '0;
        endcase
    end

    always_comb begin
        led_d     = led_q;
        tx_data_d = tx_data_q;
        tx_vld_d  = tx_vld_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;

        if (wr_led) led_d = io_dout[LED_W-1:0];

        if (wr_tx && (!tx_vld_q || tx_rdy)) begin
            tx_data_d = io_dout;
            tx_vld_d  = 1'b1;
        end else if (tx_vld_q && tx_rdy) begin
            tx_vld_d  = 1'b0;
        end

        // Clear first, then OR in this edge's events so a set is never lost.
        if (wr_err) err_d = err_q & ~io_dout[1:0];
        err_d = err_d | {udr_set, ovr_set};

        if (push) wptr_d = wptr_q + PW'(1);
        if (pop)  rptr_d = rptr_q + PW'(1);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            led_q     <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            tx_data_q <= '0;
            tx_vld_q  <= 1'b0;
            err_q     <= '0;
            cnt_q     <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
        end else begin
            led_q     <= led_d;
            sw_meta_q <= sw;
            sw_sync_q <= sw_meta_q;
            tx_data_q <= tx_data_d;
            tx_vld_q  <= tx_vld_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
        end
    end

    // Storage needs no reset: only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (push) mem[wptr_q] <= rx_data;
    end
endmodule

// File: tb/tb_mmio_io_unit.sv
// Scoreboard bench for mmio_io_unit: TX/RX payloads queued at drive time,
// compared when the DUT hands them out.
module tb_mmio_io_unit;
    logic        clk = 1'b0;
    logic        rstn;
    logic [7:0]  io_addr;
    logic [31:0] io_dout;
    logic        io_we, io_rd;
    logic [31:0] io_din;
    logic [15:0] led;
    logic [15:0] sw;
    logic [31:0] tx_data;
    logic        tx_vld, tx_rdy;
    logic [31:0] rx_data;
    logic        rx_vld, rx_rdy;

    int checks = 0;
    int errors = 0;
    logic [31:0] rxq[$];
    logic [31:0] txq[$];
    logic [31:0] d;

    always #5 clk = ~clk;

    mmio_io_unit #(.RX_DEPTH(4), .LED_W(16), .SW_W(16)) dut (
        .clk(clk), .rstn(rstn), .io_addr(io_addr), .io_dout(io_dout),
        .io_we(io_we), .io_rd(io_rd), .io_din(io_din), .led(led), .sw(sw),
        .tx_data(tx_data), .tx_vld(tx_vld), .tx_rdy(tx_rdy),
        .rx_data(rx_data), .rx_vld(rx_vld), .rx_rdy(rx_rdy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%08h exp=%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input logic [7:0] a, output logic [31:0] v);
        io_addr = a;
        io_rd   = 1'b0;
        #1 v = io_din;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] v);
        io_addr = a;
        io_rd   = 1'b1;
        #1 v = io_din;
        cyc();
        io_rd = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] v);
        io_addr = a;
        io_dout = v;
        io_we   = 1'b1;
        cyc();
        io_we = 1'b0;
    endtask

    // Consumer side of TX: the payload on a handshake must match the queue head.
    task automatic tx_take();
        if (txq.size() == 0) chk("tx_sb_empty", 32'd1, 32'd0);
        else chk("tx_payload", tx_data, txq.pop_front());
    endtask

    task automatic rx_pop_chk(input string tag);
        logic [31:0] e;
        e = (rxq.size() != 0) ? rxq.pop_front() : 32'h0;
        rd(8'h10, d);
        chk(tag, d, e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rstn = 1'b0; io_addr = '0; io_dout = '0; io_we = 0; io_rd = 0;
        sw = '0; tx_rdy = 0; rx_data = '0; rx_vld = 0;
        #1;
        chk("rst_led", 32'(led), 32'h0);
        chk("rst_tx_vld", 32'(tx_vld), 32'h0);
        chk("rst_rx_rdy", 32'(rx_rdy), 32'h1);
        peek(8'h04, d); chk("rst_tx_stat", d, 32'h1);
        peek(8'h0C, d); chk("rst_rx_stat", d, 32'h0);
        peek(8'h14, d); chk("rst_err", d, 32'h0);
        @(negedge clk) rstn = 1'b1;
        cyc();

        // LED and switches
        wr(8'h00, 32'hDEADBEEF);
        chk("led", 32'(led), 32'h0000BEEF);
        peek(8'h00, d); chk("led_rd", d, 32'h0000BEEF);
        peek(8'h20, d); chk("unmapped_rd", d, 32'h0);
        sw = 16'h00A5;
        cyc();
        peek(8'h18, d); chk("sw_lat1", d, 32'h0);
        cyc();
        peek(8'h18, d); chk("sw_lat2", d, 32'h000000A5);

        // TX load, overrun, drain, W1C
        wr(8'h08, 32'h11); txq.push_back(32'h11);
        chk("tx_vld_set", 32'(tx_vld), 32'h1);
        wr(8'h08, 32'h22);
        chk("tx_hold", tx_data, 32'h11);
        peek(8'h14, d); chk("err_ovr", d, 32'h1);
        tx_rdy = 1'b1;
        #1 tx_take();
        cyc();
        tx_rdy = 1'b0;
        chk("tx_vld_clr", 32'(tx_vld), 32'h0);
        wr(8'h14, 32'h1);
        peek(8'h14, d); chk("err_w1c", d, 32'h0);
        peek(8'h04, d); chk("tx_stat_idle", d, 32'h1);

        // RX fill to full, then drain past empty
        rx_vld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rx_data = 32'hA + 32'(i);
            chk("rx_rdy_fill", 32'(rx_rdy), 32'h1);
            rxq.push_back(rx_data);
            cyc();
        end
        rx_vld = 1'b0;
        chk("rx_rdy_full", 32'(rx_rdy), 32'h0);
        peek(8'h0C, d); chk("rx_stat_full", d, 32'h41);
        for (int i = 0; i < 5; i++) rx_pop_chk("rx_drain");
        peek(8'h14, d); chk("err_udr", d, 32'h2);
        wr(8'h14, 32'h3);

        // Simultaneous push/pop at count=2, crossing pointer wrap
        rx_vld = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rx_data = 32'h100 + 32'(i);
            rxq.push_back(rx_data);
            cyc();
        end
        for (int i = 2; i < 5; i++) begin
            logic [31:0] e;
            rx_data = 32'h100 + 32'(i);
            rxq.push_back(rx_data);
            e = rxq.pop_front();
            rd(8'h10, d);
            chk("rx_pushpop", d, e);
        end
        rx_vld = 1'b0;
        peek(8'h0C, d); chk("rx_stat_pp", d, 32'h21);
        rx_pop_chk("rx_wrap0");
        rx_pop_chk("rx_wrap1");
        peek(8'h14, d); chk("err_none_pp", d, 32'h0);

        // TX store on the same edge as a completing transfer
        wr(8'h08, 32'h33); txq.push_back(32'h33);
        tx_rdy = 1'b1; io_addr = 8'h08; io_dout = 32'h44; io_we = 1'b1;
        #1 tx_take();
        txq.push_back(32'h44);
        cyc();
        io_we = 1'b0; tx_rdy = 1'b0;
        chk("tx_reload_vld", 32'(tx_vld), 32'h1);
        chk("tx_reload_data", tx_data, txq[0]);
        peek(8'h14, d); chk("tx_reload_noovr", d, 32'h0);
        tx_rdy = 1'b1;
        #1 tx_take();
        cyc();
        tx_rdy = 1'b0;
        chk("tx_drained", 32'(tx_vld), 32'h0);

        // Asynchronous reset mid-transfer
        rx_vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rx_data = 32'h200 + 32'(i);
            rxq.push_back(rx_data);
            cyc();
        end
        rx_vld = 1'b0;
        wr(8'h08, 32'h55);
        peek(8'h0C, d); chk("rx_stat_3", d, 32'h31);
        chk("tx_vld_pre_rst", 32'(tx_vld), 32'h1);
        #2 rstn = 1'b0;
        #1;
        chk("arst_led", 32'(led), 32'h0);
        chk("arst_tx_vld", 32'(tx_vld), 32'h0);
        chk("arst_tx_data", tx_data, 32'h0);
        chk("arst_rx_rdy", 32'(rx_rdy), 32'h1);
        peek(8'h0C, d); chk("arst_rx_stat", d, 32'h0);
        peek(8'h04, d); chk("arst_tx_stat", d, 32'h1);
        peek(8'h18, d); chk("arst_sw", d, 32'h0);
        rxq.delete();
        txq.delete();
        @(negedge clk) rstn = 1'b1;
        cyc();

        // FIFO usable again from the reset pointers
        rx_vld = 1'b1; rx_data = 32'h300; rxq.push_back(rx_data);
        cyc();
        rx_vld = 1'b0;
        peek(8'h0C, d); chk("post_rst_stat", d, 32'h11);
        rx_pop_chk("post_rst_rx");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
